// File: rtl/taskwait_tracker_pkg.sv
// Shared widths, counter limits and the ack beat for the taskwait tracker.
// Field widths are sized for the largest supported configuration.
package taskwait_tracker_pkg;

  localparam int TDATA_W   = 64;
  localparam int ACCS_MAX  = 64;
  localparam int ID_W_MAX  = 6;
  localparam int CNT_W_MAX = 64;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // All-ones value of a w-bit counter, right-aligned in 64 bits.
  function automatic logic [CNT_W_MAX-1:0] cnt_sat(input int w);
    return (w >= CNT_W_MAX) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  typedef struct packed {
    logic [ID_W_MAX-1:0] tdest;
    logic [TDATA_W-1:0]  tdata;
    logic                tlast;
  } ack_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr,
// wrapping modulo N.
module rr_arbiter
  import taskwait_tracker_pkg::*;
#(
  parameter  int N  = 16,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] k;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    k         = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N))
        sum = sum - (IW+1)'(N);
      k = sum[IW-1:0];
      if (!gnt_valid && req[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = k;
      end
    end
  end

endmodule

// File: rtl/taskwait_tracker.sv
// Per-accelerator outstanding-child counters gating taskwait acks,
// which are returned through a round-robin picked output register.
module taskwait_tracker
  import taskwait_tracker_pkg::*;
#(
  parameter  int MAX_ACCS = 16,
  parameter  int CNT_W    = 16,
  localparam int ID_W     = id_w(MAX_ACCS)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               taskwait_in_tvalid,
  output logic               taskwait_in_tready,
  input  logic [ID_W-1:0]    taskwait_in_tid,
  input  logic [TDATA_W-1:0] taskwait_in_tdata,
  input  logic               taskwait_in_tlast,
  output logic               taskwait_out_tvalid,
  input  logic               taskwait_out_tready,
  output logic [ID_W-1:0]    taskwait_out_tdest,
  output logic [TDATA_W-1:0] taskwait_out_tdata,
  output logic               taskwait_out_tlast,
  input  logic               spawn_evt_valid,
  input  logic [ID_W-1:0]    spawn_evt_acc,
  input  logic               finish_evt_valid,
  input  logic [ID_W-1:0]    finish_evt_acc,
  output logic               err_overflow,
  output logic               err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX  =
    CNT_W'(cnt_sat(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                run_q;
  logic [MAX_ACCS-1:0] pend_q;
  logic [MAX_ACCS-1:0] infl_q;
  logic [CNT_W-1:0]    cnt_q [MAX_ACCS];
  logic [TDATA_W-1:0]  pid_q [MAX_ACCS];
  logic [ID_W-1:0]     ptr_q;
  logic                out_vld_q;
  ack_beat_t           out_q;
  logic                ovf_q;
  logic                udf_q;

  logic [MAX_ACCS-1:0] elig;
  logic [MAX_ACCS-1:0] inc;
  logic [MAX_ACCS-1:0] dec;
  logic [MAX_ACCS-1:0] set_pend;
  logic [MAX_ACCS-1:0] set_infl;
  logic [MAX_ACCS-1:0] clr_ack;
  logic                gnt_vld;
  logic [ID_W-1:0]     gnt_idx;
  logic [ID_W-1:0]     gnt_nxt;
  logic [ID_W-1:0]     out_dest;
  logic                in_hs;
  logic                out_hs;
  logic                load;
  ack_beat_t           nxt_beat;
  logic                unused_bits;

  assign out_dest = out_q.tdest[ID_W-1:0];

  assign taskwait_in_tready =
    run_q & ~pend_q[taskwait_in_tid];

  assign in_hs  = taskwait_in_tvalid & taskwait_in_tready;
  assign out_hs = out_vld_q & taskwait_out_tready;
  assign load   = gnt_vld & (~out_vld_q | taskwait_out_tready);

  assign gnt_nxt = (gnt_idx == ID_W'(MAX_ACCS - 1)) ?
                   '0 : gnt_idx + ID_W'(1);

  always_comb begin
    elig = '0;
    for (int a = 0; a < MAX_ACCS; a++)
      elig[a] = pend_q[a] & (cnt_q[a] == CNT_ZERO) & ~infl_q[a];
  end

  always_comb begin
    inc      = '0;
    dec      = '0;
    set_pend = '0;
    set_infl = '0;
    clr_ack  = '0;
    inc[spawn_evt_acc]        = spawn_evt_valid;
    dec[finish_evt_acc]       = finish_evt_valid;
    set_pend[taskwait_in_tid] = in_hs;
    set_infl[gnt_idx]         = load;
    clr_ack[out_dest]         = out_hs;
  end

  always_comb begin
    nxt_beat       = '0;
    nxt_beat.tdest = ID_W_MAX'(gnt_idx);
    nxt_beat.tdata = pid_q[gnt_idx];
    nxt_beat.tlast = 1'b1;
  end

  rr_arbiter #(
    .N (MAX_ACCS)
  ) u_arb (
    .req       (elig),
    .ptr       (ptr_q),
    .gnt_valid (gnt_vld),
    .gnt_idx   (gnt_idx)
  );

  // Same-cycle spawn and finish on one accelerator cancel out.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int a = 0; a < MAX_ACCS; a++)
        cnt_q[a] <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      for (int a = 0; a < MAX_ACCS; a++) begin
        unique case (1'b1)
          inc[a] & ~dec[a]: begin
            if (cnt_q[a] == CNT_MAX)
              ovf_q <= 1'b1;
            else
              cnt_q[a] <= cnt_q[a] + CNT_ONE;
          end
          dec[a] & ~inc[a]: begin
            if (cnt_q[a] == CNT_ZERO)
              udf_q <= 1'b1;
            else
              cnt_q[a] <= cnt_q[a] - CNT_ONE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      run_q     <= 1'b0;
      pend_q    <= '0;
      infl_q    <= '0;
      ptr_q     <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
      for (int a = 0; a < MAX_ACCS; a++)
        pid_q[a] <= '0;
    end else begin
      run_q  <= 1'b1;
      pend_q <= (pend_q | set_pend) & ~clr_ack;
      infl_q <= (infl_q | set_infl) & ~clr_ack;
      if (in_hs)
        pid_q[taskwait_in_tid] <= taskwait_in_tdata;
      if (load) begin
        out_vld_q <= 1'b1;
        out_q     <= nxt_beat;
        ptr_q     <= gnt_nxt;
      end else if (out_hs) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign taskwait_out_tvalid = out_vld_q;
  assign taskwait_out_tdest  = out_dest;
  assign taskwait_out_tdata  = out_q.tdata;
  assign taskwait_out_tlast  = out_q.tlast;
  assign err_overflow        = ovf_q;
  assign err_underflow       = udf_q;

  // tlast carries no information on a single-beat stream.
  assign unused_bits = ^{taskwait_in_tlast, out_q.tdest};

endmodule
